// File: rtl/ref_pkg.sv
// Shared constants for the reference selector: setpoint table, FSM state type and lookup helper.
package ref_pkg;

    localparam int unsigned REF_W = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned TABLE_DEPTH = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        RAMP
    } ref_state_e;

    typedef logic signed [REF_W-1:0] ref_val_t;

    // Entry 0 stays zero so the reset output matches the reset selection.
    localparam ref_val_t REF_TABLE [TABLE_DEPTH] = '{
        ref_val_t'(0),      ref_val_t'(250),    ref_val_t'(-500),   ref_val_t'(1000),
        ref_val_t'(2000),   ref_val_t'(-300),   ref_val_t'(500),    ref_val_t'(-1000),
        ref_val_t'(4000),   ref_val_t'(-4000),  ref_val_t'(8000),   ref_val_t'(-8000),
        ref_val_t'(16000),  ref_val_t'(-16000), ref_val_t'(32767),  ref_val_t'(-32768)
    };

    function automatic ref_val_t ref_const(input logic [SEL_W-1:0] idx);
        return REF_TABLE[idx];
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop switch synchroniser plus candidate latch and saturating stability counter.
module sw_debounce #(
    parameter int unsigned SEL_BITS = 4,
    parameter int unsigned DEB_CYC  = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [SEL_BITS-1:0] sw_i,
    output logic [SEL_BITS-1:0] sw_s_o,
    output logic [SEL_BITS-1:0] cand_o,
    output logic                stable_c_o,
    output logic                done_c_o
);

    localparam int unsigned CNT_W = $clog2(DEB_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic [SEL_BITS-1:0] sync1_q, sw_s_q, cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            cand_d = sw_s_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sw_s_q  <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_i;
            sw_s_q  <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_s_o     = sw_s_q;
    assign cand_o     = cand_q;
    assign stable_c_o = (sw_s_q == cand_q);
    assign done_c_o   = (cnt_q == CNT_LAST);

endmodule

// File: rtl/ref_select_ramp.sv
// Debounced switch-selected setpoint with slew-limited output toward the selected table value.
// Macro REF_SELECT_RAMP_RAMP_EN enables the tick-paced ramp; otherwise the output jumps in one cycle.
module ref_select_ramp
    import ref_pkg::*;
#(
    parameter int unsigned CANT_BITS = REF_W,
    parameter int unsigned SEL_BITS  = SEL_W,
    parameter int unsigned DEB_CYC   = 1000,
    parameter int unsigned STEP      = 64
) (
    input  logic                        CLK_G,
    input  logic                        reset_G,
    input  logic                        En,
    input  logic [SEL_BITS-1:0]         sw,
    input  logic                        tick,
    output logic signed [CANT_BITS-1:0] Datos_out,
    output logic [SEL_BITS-1:0]         sel_idx,
    output logic                        busy,
    output logic                        settled
);

    localparam int unsigned DW = CANT_BITS + 1;
    localparam logic signed [DW-1:0]        STEP_S = DW'(STEP);
    localparam logic signed [CANT_BITS-1:0] STEP_C = CANT_BITS'(STEP);

    ref_state_e state_q, state_d;

    logic signed [CANT_BITS-1:0] out_q, out_d, target_q, target_d, lookup_c, step_out_c;
    logic [SEL_BITS-1:0]         sel_q, sel_d, sw_s_c, cand_c;
    logic                        busy_q, settled_q, settled_d;
    logic                        load_c, stable_c, done_c, last_c;
    logic signed [DW-1:0]        diff_c;

    sw_debounce #(
        .SEL_BITS (SEL_BITS),
        .DEB_CYC  (DEB_CYC)
    ) u_deb (
        .clk_i      (CLK_G),
        .rst_i      (reset_G),
        .load_i     (load_c),
        .sw_i       (sw),
        .sw_s_o     (sw_s_c),
        .cand_o     (cand_c),
        .stable_c_o (stable_c),
        .done_c_o   (done_c)
    );

    assign lookup_c = CANT_BITS'(ref_const(SEL_W'(cand_c)));

    // Difference is one bit wider so the full signed span cannot wrap.
    assign diff_c     = DW'(target_q) - DW'(out_q);
    assign last_c     = (diff_c <= STEP_S) && (diff_c >= -STEP_S);
    assign step_out_c = diff_c[DW-1] ? (out_q - STEP_C) : (out_q + STEP_C);

`ifndef REF_SELECT_RAMP_RAMP_EN
    logic unused_c;
    assign unused_c = ^{tick, last_c, step_out_c};
`endif

    always_ff @(posedge CLK_G) begin
        if (reset_G) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (En && (sw_s_c != sel_q)) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!En || !stable_c) state_d = IDLE;
                else if (done_c)      state_d = RAMP;
            end
            RAMP: begin
`ifdef REF_SELECT_RAMP_RAMP_EN
                if (tick && last_c) state_d = IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_c    = 1'b0;
        sel_d     = sel_q;
        target_d  = target_q;
        out_d     = out_q;
        settled_d = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = En && (sw_s_c != sel_q);
            end
            DEBOUNCE: begin
                if (En && stable_c && done_c) begin
                    sel_d    = cand_c;
                    target_d = lookup_c;
                end
            end
            RAMP: begin
`ifdef REF_SELECT_RAMP_RAMP_EN
                if (tick) begin
                    if (last_c) begin
                        out_d     = target_q;
                        settled_d = 1'b1;
                    end else begin
                        out_d = step_out_c;
                    end
                end
`else
                out_d     = target_q;
                settled_d = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_G) begin
        if (reset_G) begin
            out_q     <= '0;
            target_q  <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            target_q  <= target_d;
            sel_q     <= sel_d;
            busy_q    <= (state_d != IDLE);
            settled_q <= settled_d;
        end
    end

    assign Datos_out = out_q;
    assign sel_idx   = sel_q;
    assign busy      = busy_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_ref_select_ramp.sv
// Directed bench for ref_select_ramp (DEB_CYC=4, STEP=64); follows REF_SELECT_RAMP_RAMP_EN like the RTL.
module tb_ref_select_ramp;

`ifdef REF_SELECT_RAMP_RAMP_EN
    localparam int UP_CHG = 16;
    localparam int DN_CHG = 21;
`else
    localparam int UP_CHG = 1;
    localparam int DN_CHG = 1;
`endif

    logic               CLK_G = 1'b0;
    logic               reset_G = 1'b1;
    logic               En = 1'b0;
    logic [3:0]         sw = 4'd0;
    logic               tick = 1'b0;
    logic               tick_en = 1'b0;
    logic signed [15:0] Datos_out;
    logic [3:0]         sel_idx;
    logic               busy, settled;

    int total = 0;
    int bad = 0;

    ref_select_ramp #(
        .CANT_BITS (16),
        .SEL_BITS  (4),
        .DEB_CYC   (4),
        .STEP      (64)
    ) dut (
        .CLK_G     (CLK_G),
        .reset_G   (reset_G),
        .En        (En),
        .sw        (sw),
        .tick      (tick),
        .Datos_out (Datos_out),
        .sel_idx   (sel_idx),
        .busy      (busy),
        .settled   (settled)
    );

    always #5 CLK_G = ~CLK_G;

    // One-cycle tick every fourth clock while enabled.
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(posedge CLK_G);
            #1;
            tcnt = tcnt + 1;
            tick = tick_en && ((tcnt % 4) == 0);
        end
    end

    task automatic cyc();
        @(posedge CLK_G);
        #1;
    endtask

    function automatic int model_next(input int prev, input int tgt);
        int d;
        d = tgt - prev;
`ifdef REF_SELECT_RAMP_RAMP_EN
        if (d <= 64 && d >= -64) return tgt;
        return (d > 0) ? prev + 64 : prev - 64;
`else
        return tgt;
`endif
    endfunction

    // Follows the output until the first settled pulse plus three cycles, collecting statistics.
    task automatic watch(input int tgt, input int budget, output int n_chg, output int n_badstep,
                         output int n_range, output int n_settle, output logic [3:0] sel_at, output bit to);
        int prev, start, lo, hi, extra, v;
        bit done;
        prev = Datos_out; start = prev;
        lo = (start < tgt) ? start : tgt;
        hi = (start < tgt) ? tgt : start;
        n_chg = 0; n_badstep = 0; n_range = 0; n_settle = 0; sel_at = 4'hx;
        done = 1'b0; extra = 0; to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            v = Datos_out;
            if (v != prev) begin
                n_chg++;
                if (v != model_next(prev, tgt)) n_badstep++;
                if (v < lo || v > hi) n_range++;
                prev = v;
            end
            if (settled === 1'b1) begin
                n_settle++;
                if (!done) sel_at = sel_idx;
                done = 1'b1;
            end
            if (done) begin
                extra++;
                if (extra > 3) begin
                    to = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic wait_sel(input logic [3:0] want, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (sel_idx === want) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_G = 1'b1; En = 1'b0; sw = 4'd0; tick_en = 1'b0;
        repeat (3) cyc();
        total++; if (Datos_out !== 16'sd0) begin bad++; $display("FAIL reset_out: got %0d want 0", Datos_out); end
        total++; if (sel_idx !== 4'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (settled !== 1'b0) begin bad++; $display("FAIL reset_settled: got %b want 0", settled); end
        reset_G = 1'b0;
        cyc();
    endtask

    task automatic test_select_up();
        int nc, nb, nr, ns;
        logic [3:0] sa;
        bit to;
        sw = 4'd3; En = 1'b1; tick_en = 1'b1;
        repeat (5) cyc();
        total++; if (sel_idx !== 4'd0) begin bad++; $display("FAIL up_early_sel: got %0d want 0", sel_idx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL up_busy: got %b want 1", busy); end
        watch(1000, 400, nc, nb, nr, ns, sa, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL up_timeout: got %b want 0", to); end
        total++; if (nc != UP_CHG) begin bad++; $display("FAIL up_changes: got %0d want %0d", nc, UP_CHG); end
        total++; if (nb != 0) begin bad++; $display("FAIL up_step_values: got %0d wrong want 0", nb); end
        total++; if (nr != 0) begin bad++; $display("FAIL up_range: got %0d outside want 0", nr); end
        total++; if (ns != 1) begin bad++; $display("FAIL up_settled_count: got %0d want 1", ns); end
        total++; if (Datos_out !== 16'sd1000) begin bad++; $display("FAIL up_final: got %0d want 1000", Datos_out); end
        total++; if (sel_idx !== 4'd3) begin bad++; $display("FAIL up_sel: got %0d want 3", sel_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL up_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int ns;
        bit saw_busy;
        ns = 0; saw_busy = 1'b0;
        sw = 4'd2;
        cyc();
        sw = 4'd3;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (settled === 1'b1) ns++;
            if (busy === 1'b1) saw_busy = 1'b1;
        end
        total++; if (sel_idx !== 4'd3) begin bad++; $display("FAIL glitch_sel: got %0d want 3", sel_idx); end
        total++; if (Datos_out !== 16'sd1000) begin bad++; $display("FAIL glitch_out: got %0d want 1000", Datos_out); end
        total++; if (ns != 0) begin bad++; $display("FAIL glitch_settled: got %0d want 0", ns); end
        total++; if (saw_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_seen: got %b want 1", saw_busy); end
    endtask

    task automatic test_ramp_down();
        int nc, nb, nr, ns;
        logic [3:0] sa;
        bit to;
        sw = 4'd5;
        wait_sel(4'd5, 50, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL down_accept_timeout: got %b want 0", to); end
        sw = 4'd3;
        watch(-300, 600, nc, nb, nr, ns, sa, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL down_timeout: got %b want 0", to); end
        total++; if (nc != DN_CHG) begin bad++; $display("FAIL down_changes: got %0d want %0d", nc, DN_CHG); end
        total++; if (nb != 0) begin bad++; $display("FAIL down_step_values: got %0d wrong want 0", nb); end
        total++; if (nr != 0) begin bad++; $display("FAIL down_overshoot: got %0d outside want 0", nr); end
        total++; if (ns != 1) begin bad++; $display("FAIL down_settled_count: got %0d want 1", ns); end
        total++; if (sa !== 4'd5) begin bad++; $display("FAIL down_sel_at_settle: got %0d want 5", sa); end
        total++; if (Datos_out !== -16'sd300) begin bad++; $display("FAIL down_final: got %0d want -300", Datos_out); end
        // The switch moved back to 3 during the ramp; it is now taken up from IDLE.
        watch(1000, 600, nc, nb, nr, ns, sa, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL back_timeout: got %b want 0", to); end
        total++; if (nc != DN_CHG) begin bad++; $display("FAIL back_changes: got %0d want %0d", nc, DN_CHG); end
        total++; if (nb != 0) begin bad++; $display("FAIL back_step_values: got %0d wrong want 0", nb); end
        total++; if (sa !== 4'd3) begin bad++; $display("FAIL back_sel: got %0d want 3", sa); end
        total++; if (Datos_out !== 16'sd1000) begin bad++; $display("FAIL back_final: got %0d want 1000", Datos_out); end
    endtask

    task automatic test_enable();
        int nc, nb, nr, ns;
        logic [3:0] sa;
        bit to;
        En = 1'b0; sw = 4'd5;
        repeat (30) cyc();
        total++; if (sel_idx !== 4'd3) begin bad++; $display("FAIL en_off_sel: got %0d want 3", sel_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_off_busy: got %b want 0", busy); end
        En = 1'b1;
        repeat (4) cyc();
        total++; if (sel_idx !== 4'd3) begin bad++; $display("FAIL en_early_sel: got %0d want 3", sel_idx); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL en_deb_busy: got %b want 1", busy); end
        cyc();
        total++; if (sel_idx !== 4'd5) begin bad++; $display("FAIL en_accept_sel: got %0d want 5", sel_idx); end
        watch(-300, 600, nc, nb, nr, ns, sa, to);
        total++; if (Datos_out !== -16'sd300) begin bad++; $display("FAIL en_final: got %0d want -300", Datos_out); end
        total++; if (ns != 1) begin bad++; $display("FAIL en_settled_count: got %0d want 1", ns); end
    endtask

    task automatic test_reset_mid();
        bit to;
        sw = 4'd3;
        wait_sel(4'd3, 50, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL mid_accept_timeout: got %b want 0", to); end
`ifdef REF_SELECT_RAMP_RAMP_EN
        repeat (10) cyc();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        total++;
        if (Datos_out <= -16'sd300 || Datos_out >= 16'sd1000) begin
            bad++; $display("FAIL mid_partial: got %0d want strictly between -300 and 1000", Datos_out);
        end
`else
        total++; if (Datos_out !== -16'sd300) begin bad++; $display("FAIL jump_hold: got %0d want -300", Datos_out); end
        cyc();
        total++; if (Datos_out !== 16'sd1000) begin bad++; $display("FAIL jump_out: got %0d want 1000", Datos_out); end
        total++; if (settled !== 1'b1) begin bad++; $display("FAIL jump_settled: got %b want 1", settled); end
`endif
        reset_G = 1'b1; sw = 4'd0;
        cyc();
        total++; if (Datos_out !== 16'sd0) begin bad++; $display("FAIL mid_reset_out: got %0d want 0", Datos_out); end
        total++; if (sel_idx !== 4'd0) begin bad++; $display("FAIL mid_reset_sel: got %0d want 0", sel_idx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
        total++; if (settled !== 1'b0) begin bad++; $display("FAIL mid_reset_settled: got %b want 0", settled); end
        reset_G = 1'b0;
        repeat (12) cyc();
        total++; if (Datos_out !== 16'sd0) begin bad++; $display("FAIL post_reset_out: got %0d want 0", Datos_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_select_up();
        test_glitch();
        test_ramp_down();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
